// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for the iterative shift/move unit.
// The master drives requests and accepts results; the slave is the unit itself.
interface shift_unit_seq_if #(
  parameter int BITS = 16
);
  localparam int AMT_W = $clog2(BITS);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [BITS-1:0]   a_in;
  logic [AMT_W-1:0]  amt;
  logic [BITS/2-1:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [BITS-1:0]   result;
  logic              carry_out;
  logic              zero;

  modport master (
    output in_valid, op, a_in, amt, imm, out_ready,
    input  in_ready, out_valid, result, carry_out, zero
  );

  modport slave (
    input  in_valid, op, a_in, amt, imm, out_ready,
    output in_ready, out_valid, result, carry_out, zero
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/move unit: shifts up to STEP bits per cycle, and publishes
// result, carry and zero together in DONE until the consumer takes them.
module shift_unit_seq #(
  parameter int BITS = 16,
  parameter int STEP = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_unit_seq_if.slave     bus
);
  localparam int AMT_W = $clog2(BITS);
  localparam int HALF  = BITS / 2;

  localparam logic [2:0] OP_ASR   = 3'b000;
  localparam logic [2:0] OP_LSR   = 3'b001;
  localparam logic [2:0] OP_ROR   = 3'b010;
  localparam logic [2:0] OP_LSL   = 3'b011;
  localparam logic [2:0] OP_MOVIS = 3'b100;
  localparam logic [2:0] OP_MOVI  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_q;
  logic [BITS-1:0]  work;
  logic [AMT_W-1:0] rem;
  logic             carry_q;
  logic [BITS-1:0]  result_q;
  logic             carry_out_q;
  logic             zero_q;

  logic             accept;
  logic             direct;
  logic [BITS-1:0]  direct_res;
  logic             acc_carry;
  logic [AMT_W-1:0] step_amt;
  logic [BITS-1:0]  work_nxt;
  logic             last_step;

  assign accept = bus.in_valid && bus.in_ready;
  // Moves, reserved ops and zero-amount shifts finish on the accept edge.
  assign direct = bus.op[2] || (bus.amt == '0);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    direct_res = bus.a_in;
    case (bus.op)
      OP_MOVIS: direct_res = {bus.imm, bus.a_in[HALF-1:0]};
      OP_MOVI:  direct_res = {{HALF{1'b0}}, bus.imm};
      default:  direct_res = bus.a_in;
    endcase
  end

  // Carry is the last bit that will leave the operand; known at accept time.
  always_comb begin
    acc_carry = 1'b0;
    if (bus.amt != '0) begin
      case (bus.op)
        OP_ASR, OP_LSR, OP_ROR: acc_carry = bus.a_in[bus.amt - AMT_W'(1)];
        OP_LSL:                 acc_carry = bus.a_in[BITS - int'(bus.amt)];
        default:                acc_carry = 1'b0;
      endcase
    end
  end

  always_comb begin
    step_amt = (int'(rem) > STEP) ? AMT_W'(STEP) : rem;
    work_nxt = work;
    case (op_q)
      OP_ASR:  work_nxt = $unsigned($signed(work) >>> step_amt);
      OP_LSR:  work_nxt = work >> step_amt;
      OP_ROR:  work_nxt = (work >> step_amt) | (work << (BITS - int'(step_amt)));
      OP_LSL:  work_nxt = work << step_amt;
      default: work_nxt = work;
    endcase
  end

  assign last_step = (rem == step_amt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = direct ? S_DONE : S_SHIFT;
      S_SHIFT: if (last_step) state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == S_IDLE);
    bus.out_valid = (state == S_DONE);
  end

  // NOTE: the working registers are reset too; a reset mid-shift must leave
  // nothing that could surface as a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      work        <= '0;
      rem         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.op;
            work    <= bus.a_in;
            rem     <= bus.amt;
            carry_q <= acc_carry;
            if (direct) begin
              result_q    <= direct_res;
              carry_out_q <= 1'b0;
              zero_q      <= (direct_res == '0);
            end
          end
        end
        S_SHIFT: begin
          work <= work_nxt;
          rem  <= rem - step_amt;
          if (last_step) begin
            result_q    <= work_nxt;
            carry_out_q <= carry_q;
            zero_q      <= (work_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq (BITS=16, STEP=4): directed requests push
// expected responses; a negedge monitor checks every presented result.
module tb_shift_unit_seq;
  localparam int BITS = 16;
  localparam int STEP = 4;

  localparam logic [2:0] ASR = 3'b000, LSR = 3'b001, ROR = 3'b010, LSL = 3'b011;
  localparam logic [2:0] MOVIS = 3'b100, MOVI = 3'b101, RSV = 3'b110;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    int          n;   // edges from accept to out_valid
    int          e;   // cycle number of the accept edge
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t head;
  logic prev_v;

  shift_unit_seq_if #(.BITS(BITS)) bus ();

  shift_unit_seq #(.BITS(BITS), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks the head entry every cycle out_valid is high (stability),
  // latency on the rising cycle, and pops on the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          if (!prev_v) check("unexpected_output", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          head = sb[0];
          if (!prev_v) check("latency", cyc - head.e, head.n);
          check("result", {16'd0, bus.result}, {16'd0, head.res});
          check("carry", {31'd0, bus.carry_out}, {31'd0, head.c});
          check("zero", {31'd0, bus.zero}, {31'd0, head.z});
          check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      prev_v = bus.out_valid;
    end
  end

  // Caller is at posedge+1. Returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [3:0] amt,
                       input logic [7:0] imm, input logic [15:0] res, input logic c,
                       input int n, input bit push, input bit hold);
    exp_t e;
    bit   ok;
    bus.op       = op;
    bus.a_in     = a;
    bus.amt      = amt;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e.res = res;
    e.c   = c;
    e.z   = (res == 16'h0000);
    e.n   = n;
    e.e   = cyc + 1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a_in      = '0;
    bus.amt       = '0;
    bus.imm       = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_carry", {31'd0, bus.carry_out}, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic shifts and moves, one at a time.
    issue(ASR,   16'h8010, 4'd5,  8'h00, 16'hFC00, 1'b1, 2, 1, 0); drain();
    issue(ROR,   16'h1234, 4'd8,  8'h00, 16'h3412, 1'b0, 2, 1, 0); drain();
    issue(LSL,   16'h00F1, 4'd12, 8'h00, 16'h1000, 1'b1, 3, 1, 0); drain();
    issue(MOVIS, 16'h12AB, 4'd3,  8'h7F, 16'h7FAB, 1'b0, 0, 1, 0); drain();
    issue(MOVI,  16'hFFFF, 4'd0,  8'h00, 16'h0000, 1'b0, 0, 1, 0); drain();

    // Consumer stall: result held for several cycles, then released.
    bus.out_ready = 1'b0;
    issue(LSR, 16'h0000, 4'd0, 8'h00, 16'h0000, 1'b0, 0, 1, 0);
    repeat (5) @(negedge clk);
    check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("stall_drained", sb.size(), 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a long shift.
    issue(LSL, 16'hFFFF, 4'd15, 8'h00, 16'h8000, 1'b1, 4, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(LSR, 16'h8000, 4'd15, 8'h00, 16'h0001, 1'b0, 4, 1, 0); drain();

    // Back-to-back with in_valid held high throughout.
    issue(ASR,   16'h7FFF, 4'd3,  8'h00, 16'h0FFF, 1'b1, 1, 1, 1);
    issue(LSR,   16'hF00F, 4'd4,  8'h00, 16'h0F00, 1'b1, 1, 1, 1);
    issue(ROR,   16'h0001, 4'd1,  8'h00, 16'h8000, 1'b1, 1, 1, 1);
    issue(LSL,   16'h8001, 4'd1,  8'h00, 16'h0002, 1'b1, 1, 1, 1);
    issue(RSV,   16'hBEEF, 4'd3,  8'h00, 16'hBEEF, 1'b0, 0, 1, 1);
    issue(ROR,   16'hABCD, 4'd0,  8'h00, 16'hABCD, 1'b0, 0, 1, 1);
    issue(ASR,   16'h8000, 4'd15, 8'h00, 16'hFFFF, 1'b0, 4, 1, 1);
    issue(LSR,   16'h0008, 4'd4,  8'h00, 16'h0000, 1'b1, 1, 1, 1);
    issue(ROR,   16'h000F, 4'd9,  8'h00, 16'h0780, 1'b0, 3, 1, 1);
    issue(ROR,   16'h1234, 4'd4,  8'h00, 16'h4123, 1'b0, 1, 1, 1);
    issue(LSL,   16'h0003, 4'd15, 8'h00, 16'h8000, 1'b1, 4, 1, 1);
    issue(MOVIS, 16'hFFFF, 4'd7,  8'h00, 16'h00FF, 1'b0, 0, 1, 0);
    drain();
    repeat (4) @(negedge clk);
    check("final_idle", {31'd0, bus.in_ready}, 32'd1);
    check("final_queue", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
